// File: rtl/memaccess.sv
// memaccess: pipeline memory-access stage between execute and writeback.
// Captures one instruction from execute, runs at most one load/store on the
// SRAM-like data port, aligns and extends load data, and registers the
// writeback controls and PC for the next stage.
//
// Data-port handshake: data_req is high for every cycle spent in REQ and all
// data_* fields are held constant for that whole time. The request is taken
// in the cycle data_addr_ok is high. The transaction then ends in the first
// cycle data_data_ok is high, which may be that same cycle. data_addr_ok only
// counts in REQ. data_data_ok only counts in REQ (together with data_addr_ok)
// or in WAIT.
module memaccess (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_inst_opreat,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic        ex_write_reg,
    input  logic [4:0]  ex_write_reg_address,
    input  logic [31:0] ex_result,
    input  logic        ex_write_hi,
    input  logic        ex_write_lo,
    input  logic [31:0] ex_hi_value,
    input  logic [31:0] ex_lo_value,
    output logic        am_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        write_reg,
    output logic [4:0]  write_reg_address,
    output logic [31:0] write_reg_value,
    output logic        write_hi,
    output logic        write_lo,
    output logic [31:0] write_hi_value,
    output logic [31:0] write_lo_value,
    output logic        inst_opreat,
    output logic [31:0] am_pc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Captured instruction
    logic        r_read;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic        r_wreg;
    logic [4:0]  r_wreg_addr;
    logic [31:0] r_result;
    logic        r_whi;
    logic        r_wlo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_opreat;
    logic [31:0] r_pc;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_alu_accept;
    logic        w_complete;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_accept     = (r_state == S_IDLE) && ex_valid;
    assign w_is_mem     = mem_read || mem_write;
    assign w_alu_accept = w_accept && !w_is_mem;
    assign w_complete   = ((r_state == S_REQ) && data_addr_ok && data_data_ok) ||
                          ((r_state == S_WAIT) && data_data_ok);

    assign am_stall   = (r_state != S_IDLE);
    assign data_req   = (r_state == S_REQ);
    assign data_wr    = r_write;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign dbg_state  = r_state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mem) w_next = S_REQ;
            S_REQ:  if (data_addr_ok) w_next = data_data_ok ? S_IDLE : S_WAIT;
            S_WAIT: if (data_data_ok) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the presented instruction whenever the stage is free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_addr      <= 32'd0;
            r_sdata     <= 32'd0;
            r_wreg      <= 1'b0;
            r_wreg_addr <= 5'd0;
            r_result    <= 32'd0;
            r_whi       <= 1'b0;
            r_wlo       <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_opreat    <= 1'b0;
            r_pc        <= 32'd0;
        end else if (w_accept) begin
            r_read      <= mem_read;
            r_write     <= mem_write;
            r_size      <= mem_size;
            r_signed    <= mem_signed;
            r_addr      <= mem_addr;
            r_sdata     <= store_data;
            r_wreg      <= ex_write_reg;
            r_wreg_addr <= ex_write_reg_address;
            r_result    <= ex_result;
            r_whi       <= ex_write_hi;
            r_wlo       <= ex_write_lo;
            r_hi        <= ex_hi_value;
            r_lo        <= ex_lo_value;
            r_opreat    <= ex_inst_opreat;
            r_pc        <= ex_pc;
        end
    end

    // Store data replicated across every lane the access may hit
    always_comb begin
        case (r_size)
            2'd0:    data_wdata = {4{r_sdata[7:0]}};
            2'd1:    data_wdata = {2{r_sdata[15:0]}};
            default: data_wdata = r_sdata;
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        w_byte = data_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = data_rdata[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'd0:    w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = data_rdata;
        endcase
    end

    // Writeback registers: ALU accept, memory completion, or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg         <= 1'b0;
            write_reg_address <= 5'd0;
            write_reg_value   <= 32'd0;
            write_hi          <= 1'b0;
            write_lo          <= 1'b0;
            write_hi_value    <= 32'd0;
            write_lo_value    <= 32'd0;
            inst_opreat       <= 1'b0;
            am_pc             <= 32'd0;
        end else if (w_alu_accept) begin
            write_reg         <= ex_write_reg;
            write_reg_address <= ex_write_reg_address;
            write_reg_value   <= ex_result;
            write_hi          <= ex_write_hi;
            write_lo          <= ex_write_lo;
            write_hi_value    <= ex_hi_value;
            write_lo_value    <= ex_lo_value;
            inst_opreat       <= ex_inst_opreat;
            am_pc             <= ex_pc;
        end else if (w_complete) begin
            write_reg         <= r_wreg;
            write_reg_address <= r_wreg_addr;
            write_reg_value   <= r_read ? w_load_data : r_result;
            write_hi          <= r_whi;
            write_lo          <= r_wlo;
            write_hi_value    <= r_hi;
            write_lo_value    <= r_lo;
            inst_opreat       <= r_opreat;
            am_pc             <= r_pc;
        end else begin
            write_reg   <= 1'b0;
            write_hi    <= 1'b0;
            write_lo    <= 1'b0;
            inst_opreat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memaccess.sv
// Testbench for memaccess: directed ALU, load, store, handshake-stretch,
// fast-slave and mid-transaction reset vectors with a writeback scoreboard.
module tb_memaccess;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wval;
        logic        whi;
        logic        wlo;
        logic [31:0] hiv;
        logic [31:0] lov;
        logic        op;
        logic [31:0] pc;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_inst_opreat = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_signed = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] store_data = '0;
    logic        ex_write_reg = 1'b0;
    logic [4:0]  ex_write_reg_address = '0;
    logic [31:0] ex_result = '0;
    logic        ex_write_hi = 1'b0;
    logic        ex_write_lo = 1'b0;
    logic [31:0] ex_hi_value = '0;
    logic [31:0] ex_lo_value = '0;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        am_stall, data_req, data_wr;
    logic [1:0]  data_size, dbg_state;
    logic [31:0] data_addr, data_wdata;
    logic        write_reg, write_hi, write_lo, inst_opreat;
    logic [4:0]  write_reg_address;
    logic [31:0] write_reg_value, write_hi_value, write_lo_value, am_pc;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    memaccess dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_inst_opreat(ex_inst_opreat), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_signed(mem_signed), .mem_addr(mem_addr),
        .store_data(store_data), .ex_write_reg(ex_write_reg),
        .ex_write_reg_address(ex_write_reg_address), .ex_result(ex_result),
        .ex_write_hi(ex_write_hi), .ex_write_lo(ex_write_lo),
        .ex_hi_value(ex_hi_value), .ex_lo_value(ex_lo_value),
        .am_stall(am_stall), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .write_reg(write_reg),
        .write_reg_address(write_reg_address), .write_reg_value(write_reg_value),
        .write_hi(write_hi), .write_lo(write_lo), .write_hi_value(write_hi_value),
        .write_lo_value(write_lo_value), .inst_opreat(inst_opreat), .am_pc(am_pc),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every visible writeback must match the head of the queue
    always @(negedge clk) begin
        wb_t act;
        wb_t exp;
        if (!rst && (write_reg || write_hi || write_lo || inst_opreat)) begin
            act = '{write_reg, write_reg_address, write_reg_value, write_hi, write_lo,
                    write_hi_value, write_lo_value, inst_opreat, am_pc};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wb: got %h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL wb: got %h expected %h", act, exp);
                end
            end
        end
    end

    task automatic clear_ex();
        ex_valid = 1'b0; ex_inst_opreat = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'd0; mem_signed = 1'b0; ex_write_reg = 1'b0;
        ex_write_hi = 1'b0; ex_write_lo = 1'b0;
        mem_addr = 32'hDEAD_0000; store_data = 32'hBAD0_BAD0;
    endtask

    task automatic issue_alu(input logic [4:0] rd, input logic [31:0] val,
                             input logic wreg, input logic whi, input logic wlo,
                             input logic [31:0] hiv, input logic [31:0] lov,
                             input logic op, input logic [31:0] pc);
        clear_ex();
        ex_valid = 1'b1; ex_write_reg = wreg; ex_write_reg_address = rd;
        ex_result = val; ex_write_hi = whi; ex_write_lo = wlo;
        ex_hi_value = hiv; ex_lo_value = lov; ex_inst_opreat = op; ex_pc = pc;
        exp_q.push_back('{wreg, rd, val, whi, wlo, hiv, lov, op, pc});
        #1;
        check("alu_stall", {31'd0, am_stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic mem_op(input logic is_load, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic wreg, input logic [31:0] result,
                          input logic [31:0] rdata, input int alat, input int dlat,
                          input logic [31:0] exp_val, input logic [31:0] exp_wdata,
                          input logic [31:0] pc);
        clear_ex();
        ex_valid = 1'b1; mem_read = is_load; mem_write = !is_load; mem_size = size;
        mem_signed = sgn; mem_addr = addr; store_data = sdata; ex_write_reg = wreg;
        ex_write_reg_address = rd; ex_result = result; ex_pc = pc;
        ex_hi_value = 32'h0; ex_lo_value = 32'h0;
        if (wreg) exp_q.push_back('{1'b1, rd, exp_val, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, pc});
        @(posedge clk); #1;
        clear_ex();
        data_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= alat; c++) begin
            check("req_high", {31'd0, data_req}, 32'd1);
            check("req_wr", {31'd0, data_wr}, {31'd0, !is_load});
            check("req_size", {30'd0, data_size}, {30'd0, size});
            check("req_addr", data_addr, addr);
            check("req_wdata", data_wdata, exp_wdata);
            check("req_stall", {31'd0, am_stall}, 32'd1);
            if (c == alat) begin
                data_addr_ok = 1'b1;
                if (dlat == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
            end
            @(posedge clk); #1;
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hDEAD_BEEF;
        end
        for (int d = 1; d <= dlat; d++) begin
            check("wait_req_low", {31'd0, data_req}, 32'd0);
            check("wait_stall", {31'd0, am_stall}, 32'd1);
            if (d == dlat) begin data_data_ok = 1'b1; data_rdata = rdata; end
            @(posedge clk); #1;
            data_data_ok = 1'b0; data_rdata = 32'hDEAD_BEEF;
        end
        check("done_stall", {31'd0, am_stall}, 32'd0);
        check("done_wreg", {31'd0, write_reg}, {31'd0, wreg});
    endtask

    // Main stimulus
    initial begin
        clear_ex();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_write_reg", {31'd0, write_reg}, 32'd0);
        check("rst_value", write_reg_value, 32'd0);
        check("rst_pc", am_pc, 32'd0);
        check("rst_req", {31'd0, data_req}, 32'd0);
        check("rst_stall", {31'd0, am_stall}, 32'd0);

        // Back-to-back ALU ops, then one with HI/LO and branch flag
        issue_alu(5'd1, 32'h11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h100);
        issue_alu(5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h104);
        issue_alu(5'd3, 32'h33, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h108);
        issue_alu(5'd4, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10C);
        issue_alu(5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h200);
        clear_ex();
        @(posedge clk); #1;

        // Loads: is_load size sgn addr sdata rd wreg result rdata alat dlat exp wdata pc
        mem_op(1, 2'd0, 1, 32'h1003, 0, 5'd5, 1, 32'h5555_5555, 32'h80FF_1234, 0, 1, 32'hFFFF_FF80, 0, 32'h300);
        mem_op(1, 2'd0, 0, 32'h1003, 0, 5'd6, 1, 32'h5555_5555, 32'h80FF_1234, 0, 1, 32'h0000_0080, 0, 32'h304);
        mem_op(1, 2'd1, 1, 32'h1002, 0, 5'd7, 1, 32'h5555_5555, 32'h80FF_1234, 0, 1, 32'hFFFF_80FF, 0, 32'h308);
        mem_op(1, 2'd1, 1, 32'h1000, 0, 5'd8, 1, 32'h5555_5555, 32'h80FF_1234, 0, 1, 32'h0000_1234, 0, 32'h30C);
        mem_op(1, 2'd2, 0, 32'h1000, 0, 5'd9, 1, 32'h5555_5555, 32'h80FF_1234, 0, 1, 32'h80FF_1234, 0, 32'h310);

        // Stores
        mem_op(0, 2'd0, 0, 32'h2001, 32'h0000_00AB, 5'd0, 0, 32'h77, 32'h0, 0, 1, 32'h0, 32'hABAB_ABAB, 32'h400);
        mem_op(0, 2'd1, 0, 32'h2002, 32'h1234_5678, 5'd0, 0, 32'h77, 32'h0, 0, 1, 32'h0, 32'h5678_5678, 32'h404);
        mem_op(0, 2'd2, 0, 32'h2004, 32'hCAFE_BABE, 5'd0, 0, 32'h77, 32'h0, 0, 1, 32'h0, 32'hCAFE_BABE, 32'h408);

        // Handshake strobes while idle must be ignored
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        check("idle_ok_req", {31'd0, data_req}, 32'd0);
        check("idle_ok_stall", {31'd0, am_stall}, 32'd0);
        check("idle_ok_wreg", {31'd0, write_reg}, 32'd0);

        // Stretched handshake, then fast slave, then an ALU op right after
        mem_op(1, 2'd2, 0, 32'h3000, 0, 5'd10, 1, 32'h5555_5555, 32'h1357_9BDF, 3, 2, 32'h1357_9BDF, 0, 32'h500);
        mem_op(1, 2'd0, 0, 32'h1001, 0, 5'd11, 1, 32'h5555_5555, 32'h80FF_1234, 0, 0, 32'h0000_0012, 0, 32'h504);
        issue_alu(5'd12, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h508);
        clear_ex();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset while waiting for data
        clear_ex();
        ex_valid = 1'b1; mem_read = 1'b1; mem_size = 2'd2; mem_addr = 32'h1000;
        ex_write_reg = 1'b1; ex_write_reg_address = 5'd13; ex_pc = 32'h600;
        @(posedge clk); #1;
        clear_ex();
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        check("pre_rst_wait", {31'd0, am_stall}, 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_req", {31'd0, data_req}, 32'd0);
        check("mid_rst_stall", {31'd0, am_stall}, 32'd0);
        check("mid_rst_value", write_reg_value, 32'd0);
        check("mid_rst_pc", am_pc, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        check("post_rst_wreg", {31'd0, write_reg}, 32'd0);
        check("post_rst_value", write_reg_value, 32'd0);
        check("post_rst_stall", {31'd0, am_stall}, 32'd0);
        @(posedge clk); #1;
        check("post_rst_wreg2", {31'd0, write_reg}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
